ysyx_22041071_regfile_sb: RTL

Architectural integer register file with an attached write-back scoreboard, sitting at the receiving end of the WB stage's output handshake (valid/ready, PC, instruction, write enable, destination, data). It performs the register write, supplies two combinational read ports with same-cycle write bypass to ID, and tracks in-flight destinations so ID can detect RAW hazards. It also emits a registered per-instruction commit record and a retired-instruction counter for difftest.

---
 rtl/ysyx_22041071_regfile_sb.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ysyx_22041071_regfile_sb.sv
// Integer register file with write-back scoreboard: WB writes, two bypassed read ports, RAW tracking, commit record.
// Latency: reads, busy and iss_stall are combinational; register write and commit record appear one cycle after wb fire.
// Backpressure: wb_ready is low only across reset; issue is held via iss_stall while a destination has 3 writers in flight.
module ysyx_22041071_regfile_sb #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int INS_W  = 32,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_pc,
    input  logic [INS_W-1:0]  wb_ins,
    input  logic              wb_w_en,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [4:0]        rs1_addr,
    input  logic [4:0]        rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              iss_valid,
    input  logic              iss_w_en,
    input  logic [4:0]        iss_rd,
    output logic              iss_stall,
    output logic              commit_valid,
    output logic [ADDR_W-1:0] commit_pc,
    output logic [INS_W-1:0]  commit_ins,
    output logic [63:0]       commit_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs    [32];
    logic [CNT_W-1:0]  cnt     [32];
    logic [CNT_W-1:0]  cnt_nxt [32];

    logic wb_fire;
    logic wr_en;
    logic iss_wr;
    logic inc_en;

    assign wb_fire = wb_valid & wb_ready;
    // A retire that actually writes an architectural register (x0 excluded).
    assign wr_en   = wb_fire & wb_w_en & (wb_rd != 5'd0);
    assign iss_wr  = iss_valid & iss_w_en & (iss_rd != 5'd0);

    // A saturated counter blocks issue unless a writer to the same register retires this cycle.
    assign iss_stall = iss_wr & (cnt[iss_rd] == CNT_MAX) & !(wr_en & (wb_rd == iss_rd));
    assign inc_en    = iss_wr & !iss_stall;

    // Busy clears early when the last outstanding writer retires this cycle; data then comes from bypass.
    assign rs1_busy = (rs1_addr != 5'd0) & (cnt[rs1_addr] != '0)
                    & !((cnt[rs1_addr] == CNT_ONE) & wr_en & (wb_rd == rs1_addr));
    assign rs2_busy = (rs2_addr != 5'd0) & (cnt[rs2_addr] != '0)
                    & !((cnt[rs2_addr] == CNT_ONE) & wr_en & (wb_rd == rs2_addr));

    // Read port 1: x0 is hardwired zero, same-cycle write data wins over stored value.
    always_comb begin
        rs1_data = regs[rs1_addr];
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end else if (wr_en && (wb_rd == rs1_addr)) begin
            rs1_data = wb_data;
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        rs2_data = regs[rs2_addr];
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end else if (wr_en && (wb_rd == rs2_addr)) begin
            rs2_data = wb_data;
        end
    end

    // Next in-flight count per register: issue and retire on the same register cancel; retire never wraps below 0.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cnt_nxt[r] = cnt[r];
            if (r != 0) begin
                if (inc_en && (iss_rd == 5'(r)) && !(wr_en && (wb_rd == 5'(r)))) begin
                    cnt_nxt[r] = cnt[r] + CNT_ONE;
                end else if (wr_en && (wb_rd == 5'(r)) && !(inc_en && (iss_rd == 5'(r)))
                             && (cnt[r] != '0)) begin
                    cnt_nxt[r] = cnt[r] - CNT_ONE;
                end
            end
        end
    end

    // Architectural state and scoreboard counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
        end else begin
            if (wr_en) begin
                regs[wb_rd] <= wb_data;
            end
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
        end
    end

    // Handshake ready and the per-instruction commit record for difftest.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_ready     <= 1'b0;
            commit_valid <= 1'b0;
            commit_pc    <= '0;
            commit_ins   <= '0;
            commit_cnt   <= '0;
        end else begin
            wb_ready     <= 1'b1;
            commit_valid <= wb_fire;
            if (wb_fire) begin
                commit_pc  <= wb_pc;
                commit_ins <= wb_ins;
                commit_cnt <= commit_cnt + 64'd1;
            end
        end
    end

`ifndef SYNTHESIS
    // Report a retire to a register that has no writer on record.
    always @(posedge clk) begin
        if (!reset && wr_en && (cnt[wb_rd] == '0) && !(inc_en && (iss_rd == wb_rd))) begin
            $display("regfile_sb: scoreboard underflow on x%0d", wb_rd);
        end
    end
`endif

endmodule
